seq_divider: RTL and testbench

Parametrised multi-cycle integer divider for the M-extension execute stage. It supersedes the fixed 32-bit radix-2 divider. It adds:
- configurable operand width and bits retired per cycle
- an explicit start/done handshake
- a kill input
- single-cycle fast paths for RISC-V divide-by-zero and signed-overflow results

The execute stage holds the pipeline while busy is high and captures res on done.

---
 rtl/seq_divider.sv | 208 ++++++++++++++++++++
 tb/tb_seq_divider.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider for the M-extension execute stage.
// Retires BPC quotient bits per cycle; divide-by-zero and overflow finish in one cycle.
module seq_divider #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      divsel,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int CYCLES = XLEN / BPC;
    localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    localparam logic [2:0] SEL_DIV  = 3'b001;
    localparam logic [2:0] SEL_DIVU = 3'b010;
    localparam logic [2:0] SEL_REM  = 3'b011;
    localparam logic [2:0] SEL_REMU = 3'b100;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_TOP = CW'(CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   prem_q, prem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            rem_sel_q, rem_sel_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            legal;
    logic            is_signed;
    logic            want_rem;
    logic            accept;
    logic            b_zero;
    logic            ovf;
    logic            fast;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] fast_res;

    logic [XLEN:0]   s_rem;
    logic [XLEN-1:0] s_quo;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] calc_res;

    // Request decode and operand conditioning
    always_comb begin
        legal     = 1'b0;
        is_signed = 1'b0;
        want_rem  = 1'b0;
        unique case (divsel)
            SEL_DIV:  begin legal = 1'b1; is_signed = 1'b1; end
            SEL_DIVU: begin legal = 1'b1; end
            SEL_REM:  begin legal = 1'b1; is_signed = 1'b1; want_rem = 1'b1; end
            SEL_REMU: begin legal = 1'b1; want_rem = 1'b1; end
            default:  begin legal = 1'b0; end
        endcase
    end

    always_comb begin
        accept   = start && legal && !kill && (state_q != CALC);
        a_abs    = (is_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
        b_abs    = (is_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
        b_zero   = (b == '0);
        ovf      = is_signed && (a == MIN_NEG) && (b == '1);
        fast     = b_zero || ovf;
        fast_res = '0;
        if (b_zero) begin
            fast_res = want_rem ? a : '1;
        end else if (ovf) begin
            fast_res = want_rem ? '0 : MIN_NEG;
        end
    end

    // BPC restoring steps, MSB first; dividend shifts out as quotient shifts in
    always_comb begin
        s_rem = prem_q;
        s_quo = quo_q;
        for (int i = 0; i < BPC; i++) begin
            s_rem = {s_rem[XLEN-1:0], s_quo[XLEN-1]};
            s_quo = {s_quo[XLEN-2:0], 1'b0};
            if (s_rem >= {1'b0, dvs_q}) begin
                s_rem    = s_rem - {1'b0, dvs_q};
                s_quo[0] = 1'b1;
            end
        end
    end

    always_comb begin
        quo_fix  = negq_q ? (~s_quo + 1'b1) : s_quo;
        rem_fix  = negr_q ? (~s_rem[XLEN-1:0] + 1'b1) : s_rem[XLEN-1:0];
        calc_res = rem_sel_q ? rem_fix : quo_fix;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
        res  = res_q;
    end

    // Datapath next values
    always_comb begin
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_sel_d = rem_sel_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        res_d     = res_q;
        if (accept) begin
            cnt_d     = CNT_TOP;
            prem_d    = '0;
            quo_d     = a_abs;
            dvs_d     = b_abs;
            rem_sel_d = want_rem;
            negq_d    = is_signed && (a[XLEN-1] != b[XLEN-1]) && !b_zero;
            negr_d    = is_signed && a[XLEN-1];
            if (fast) begin
                res_d = fast_res;
            end
        end else if (state_q == CALC && !kill) begin
            prem_d = s_rem;
            quo_d  = s_quo;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                res_d = calc_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            prem_q    <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_sel_q <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_sel_q <= rem_sel_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            res_q     <= res_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: 32-bit radix-2 and 64-bit radix-16 instances.
// Expected results come from a behavioural RISC-V division model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start32 = 1'b0;
    logic        kill32  = 1'b0;
    logic [2:0]  sel32   = 3'b010;
    logic [31:0] a32     = '0;
    logic [31:0] b32     = '0;
    logic        busy32;
    logic        done32;
    logic [31:0] res32;

    logic        start64 = 1'b0;
    logic        kill64  = 1'b0;
    logic [2:0]  sel64   = 3'b010;
    logic [63:0] a64     = '0;
    logic [63:0] b64     = '0;
    logic        busy64;
    logic        done64;
    logic [63:0] res64;

    int errors = 0;
    int checks = 0;

    logic [31:0] q32[$];
    logic [63:0] q64[$];

    always #5 clk = ~clk;

    seq_divider #(.XLEN(32), .BPC(1)) u32 (
        .clk(clk), .rst(rst), .start(start32), .kill(kill32),
        .divsel(sel32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .res(res32)
    );

    seq_divider #(.XLEN(64), .BPC(4)) u64 (
        .clk(clk), .rst(rst), .start(start64), .kill(kill64),
        .divsel(sel64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .res(res64)
    );

    function automatic logic [31:0] model32(input logic [2:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return (sel == 3'b011 || sel == 3'b100) ? a : 32'hFFFF_FFFF;
        if ((sel == 3'b001 || sel == 3'b011) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (sel == 3'b001) ? 32'h8000_0000 : 32'd0;
        case (sel)
            3'b001:  return sa / sb;
            3'b010:  return a / b;
            3'b011:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic logic [63:0] model64(input logic [2:0] sel,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = a;
        sb = b;
        if (b == 64'd0) return (sel == 3'b011 || sel == 3'b100) ? a : '1;
        if ((sel == 3'b001 || sel == 3'b011) && a == {1'b1, 63'd0} && b == '1)
            return (sel == 3'b001) ? {1'b1, 63'd0} : 64'd0;
        case (sel)
            3'b001:  return sa / sb;
            3'b010:  return a / b;
            3'b011:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int lat32(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if ((sel == 3'b001 || sel == 3'b011) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Caller is at a negedge; start is accepted at the following posedge.
    task automatic run32(input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input string name);
        int lat;
        int nbusy;
        int elat;
        logic [31:0] exp;
        elat = lat32(sel, a, b);
        sel32 = sel; a32 = a; b32 = b; start32 = 1'b1;
        q32.push_back(model32(sel, a, b));
        lat = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            start32 = 1'b0;
            sel32 = 3'($urandom);
            a32 = $urandom;
            b32 = $urandom;
            lat++;
            if (busy32) nbusy++;
        end while (!done32 && lat < 200);
        exp = q32.pop_front();
        checks++;
        if (!done32) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles", name, lat);
        end else if (res32 !== exp) begin
            errors++;
            $display("FAIL %s res: got %h expected %h", name, res32, exp);
        end
        checks++;
        if (lat != elat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        checks++;
        if (nbusy != elat - 1) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, nbusy, elat - 1);
        end
    endtask

    // Wait for done64 and score it; the first observed cycle must already be busy when chained.
    task automatic wait64(input int elat, input bit chained, input string name);
        int lat;
        logic [63:0] exp;
        lat = 0;
        do begin
            @(negedge clk);
            start64 = 1'b0;
            a64 = {$urandom, $urandom};
            lat++;
            if (chained && lat == 1) begin
                checks++;
                if (busy64 !== 1'b1) begin
                    errors++;
                    $display("FAIL %s no_bubble: busy got %b expected 1", name, busy64);
                end
            end
        end while (!done64 && lat < 200);
        exp = q64.pop_front();
        checks++;
        if (!done64 || res64 !== exp) begin
            errors++;
            $display("FAIL %s res: got %h expected %h (done=%b)", name, res64, exp, done64);
        end
        checks++;
        if (lat != elat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd0) begin
            errors++;
            $display("FAIL reset32: busy=%b done=%b res=%h expected 0 0 0", busy32, done32, res32);
        end
        checks++;
        if (busy64 !== 1'b0 || done64 !== 1'b0 || res64 !== 64'd0) begin
            errors++;
            $display("FAIL reset64: busy=%b done=%b res=%h expected 0 0 0", busy64, done64, res64);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        run32(3'b010, 32'd100, 32'd7, "divu_100_7");
        run32(3'b100, 32'd100, 32'd7, "remu_100_7");
    endtask

    task automatic test_signed();
        run32(3'b001, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run32(3'b011, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run32(3'b011, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
        run32(3'b001, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    endtask

    task automatic test_div_zero();
        run32(3'b010, 32'd5, 32'd0, "divu_by0");
        run32(3'b011, 32'hFFFF_FFFB, 32'd0, "rem_by0");
        run32(3'b001, 32'hFFFF_FFFB, 32'd0, "div_by0");
    endtask

    task automatic test_overflow();
        run32(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run32(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            logic [31:0] ra;
            logic [31:0] rb;
            s = 3'(1 + $urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run32(s, ra, rb, "rand32");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        sel64 = 3'b010; a64 = '1; b64 = 64'd3; start64 = 1'b1;
        q64.push_back(model64(3'b010, '1, 64'd3));
        wait64(17, 1'b0, "divu64_max_3");
        sel64 = 3'b011; a64 = 64'hF000_1234_5678_9ABC; b64 = 64'h0000_0000_0012_3457; start64 = 1'b1;
        q64.push_back(model64(3'b011, 64'hF000_1234_5678_9ABC, 64'h0000_0000_0012_3457));
        wait64(17, 1'b1, "rem64_b2b");
        sel64 = 3'b001; a64 = 64'h8000_0000_0000_0000; b64 = '1; start64 = 1'b1;
        q64.push_back(model64(3'b001, 64'h8000_0000_0000_0000, '1));
        wait64(1, 1'b0, "div64_ovf");
    endtask

    task automatic test_kill();
        int saw_done;
        run32(3'b010, 32'd100, 32'd7, "divu_pre_kill");
        sel32 = 3'b010; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start32 = 1'b0;
        end
        kill32 = 1'b1;
        @(negedge clk);
        kill32 = 1'b0;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd14) begin
            errors++;
            $display("FAIL kill_calc: busy=%b done=%b res=%h expected 0 0 0000000e", busy32, done32, res32);
        end
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) saw_done++;
        end
        checks++;
        if (saw_done != 0) begin
            errors++;
            $display("FAIL kill_nodone: got %0d done pulses expected 0", saw_done);
        end
        sel32 = 3'b010; a32 = 32'd9; b32 = 32'd0; start32 = 1'b1; kill32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; kill32 = 1'b0;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd14) begin
            errors++;
            $display("FAIL kill_idle_start: busy=%b done=%b res=%h expected 0 0 0000000e", busy32, done32, res32);
        end
        sel32 = 3'b000; a32 = 32'd9; b32 = 32'd0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd14) begin
            errors++;
            $display("FAIL illegal_sel: busy=%b done=%b res=%h expected 0 0 0000000e", busy32, done32, res32);
        end
    endtask

    task automatic test_async_reset();
        sel32 = 3'b010; a32 = 32'd5000; b32 = 32'd7; start32 = 1'b1;
        sel64 = 3'b010; a64 = 64'd5000; b64 = 64'd7; start64 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start32 = 1'b0;
            start64 = 1'b0;
        end
        checks++;
        if (busy32 !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_busy: got %b expected 1", busy32);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd0) begin
            errors++;
            $display("FAIL async_rst32: busy=%b done=%b res=%h expected 0 0 0", busy32, done32, res32);
        end
        checks++;
        if (busy64 !== 1'b0 || done64 !== 1'b0 || res64 !== 64'd0) begin
            errors++;
            $display("FAIL async_rst64: busy=%b done=%b res=%h expected 0 0 0", busy64, done64, res64);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run32(3'b100, 32'd100, 32'd7, "remu_after_rst");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_random();
        test_back_to_back();
        test_kill();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
